// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - completion broadcast arbiter: per-requester 2-deep FIFOs, round-robin onto N_CDB lanes
module cdb_arbiter #(
  parameter int N_REQ = 4,
  parameter int N_CDB = 2,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0][TAG_W-1:0]       req_tag,
  input  logic [N_REQ-1:0][XLEN-1:0]        req_data,
  output logic [N_REQ-1:0]                  req_ready,
  output logic [N_CDB-1:0]                  cdb_valid,
  output logic [N_CDB-1:0][TAG_W-1:0]       cdb_tag,
  output logic [N_CDB-1:0][XLEN-1:0]        cdb_data,
  output logic [N_CDB-1:0][SRC_W-1:0]       cdb_src
);

  logic [N_REQ-1:0][1:0][TAG_W-1:0] fifo_tag;
  logic [N_REQ-1:0][1:0][XLEN-1:0]  fifo_data;
  logic [N_REQ-1:0]                 rd_ptr;
  logic [N_REQ-1:0]                 wr_ptr;
  logic [N_REQ-1:0][1:0]            count;
  logic [SRC_W-1:0]                 rr_ptr;
  logic [SRC_W-1:0]                 rr_ptr_nxt;

  logic [N_REQ-1:0]                 accept;
  logic [N_REQ-1:0]                 grant;
  logic [N_REQ-1:0][SRC_W-1:0]      pos;
  logic [N_REQ-1:0][SRC_W-1:0]      rank;
  logic [N_CDB-1:0]                 lane_valid;
  logic [N_CDB-1:0][TAG_W-1:0]      lane_tag;
  logic [N_CDB-1:0][XLEN-1:0]       lane_data;
  logic [N_CDB-1:0][SRC_W-1:0]      lane_src;

  // Ready looks only at registered occupancy; tag 0 is accepted but never stored.
  always_comb begin
    req_ready = '0;
    accept    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (count[i] < 2'd2);
      accept[i]    = req_valid[i] && req_ready[i] && !flush && (req_tag[i] != '0);
    end
  end

  // Scan position of each requester relative to rr_ptr, then its rank among non-empty heads.
  always_comb begin
    int p;
    pos  = '0;
    rank = '0;
    p    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      p = i - int'(rr_ptr);
      if (p < 0) p = p + N_REQ;
      pos[i] = p[SRC_W-1:0];
    end
    for (int i = 0; i < N_REQ; i++) begin
      for (int m = 0; m < N_REQ; m++) begin
        if (m != i && count[m] != 2'd0 && pos[m] < pos[i]) rank[i] = rank[i] + SRC_W'(1);
      end
    end
  end

  // A non-empty head wins if fewer than N_CDB heads precede it; its rank is its lane.
  always_comb begin
    int best_pos;
    int best_idx;
    int nxt;
    grant      = '0;
    lane_valid = '0;
    lane_tag   = '0;
    lane_data  = '0;
    lane_src   = '0;
    best_pos   = -1;
    best_idx   = 0;
    nxt        = 0;
    rr_ptr_nxt = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = (count[i] != 2'd0) && (int'(rank[i]) < N_CDB);
      if (grant[i] && int'(pos[i]) > best_pos) begin
        best_pos = int'(pos[i]);
        best_idx = i;
      end
    end
    for (int j = 0; j < N_CDB; j++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && int'(rank[i]) == j) begin
          lane_valid[j] = 1'b1;
          lane_tag[j]   = fifo_tag[i][rd_ptr[i]];
          lane_data[j]  = fifo_data[i][rd_ptr[i]];
          lane_src[j]   = SRC_W'(i);
        end
      end
    end
    if (grant != '0) begin
      nxt        = (best_idx + 1 == N_REQ) ? 0 : best_idx + 1;
      rr_ptr_nxt = SRC_W'(nxt);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (!reset && accept[i]) begin
        fifo_tag[i][wr_ptr[i]]  <= req_tag[i];
        fifo_data[i][wr_ptr[i]] <= req_data[i];
      end
    end
  end

  // rr_ptr survives a flush; everything else pending is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      rr_ptr    <= '0;
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      rr_ptr    <= rr_ptr_nxt;
      cdb_valid <= lane_valid;
      cdb_tag   <= lane_tag;
      cdb_data  <= lane_data;
      cdb_src   <= lane_src;
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (grant[i])  rd_ptr[i] <= ~rd_ptr[i];
        count[i] <= count[i] + {1'b0, accept[i]} - {1'b0, grant[i]};
      end
    end
  end

endmodule
